// File: rtl/fault_mem_pkg.sv
// rtl/fault_mem_pkg.sv - fault type codes and bit-mask helper for the fault memory model
// Purpose: shared fault-type encodings and a one-hot mask helper.
// Ports: none (package).
package fault_mem_pkg;

  localparam logic [2:0] FT_NONE = 3'd0;
  localparam logic [2:0] FT_SAF0 = 3'd1;
  localparam logic [2:0] FT_SAF1 = 3'd2;
  localparam logic [2:0] FT_TFUP = 3'd3;
  localparam logic [2:0] FT_TFDN = 3'd4;
  localparam logic [2:0] FT_CFIN = 3'd5;
  localparam logic [2:0] FT_CFID = 3'd6;
  localparam logic [2:0] FT_ADF  = 3'd7;

  // Wide enough for any practical word; callers truncate to DATA_WIDTH.
  localparam int MASK_W = 64;

  function automatic logic [MASK_W-1:0] bit_mask(input int unsigned idx);
    return MASK_W'(1) << idx;
  endfunction

endpackage

// File: rtl/fault_mem_inject.sv
// rtl/fault_mem_inject.sv - combinational fault injection for one memory access
// Purpose: applies the latched fault to a single access.
// Ports: ftype/vaddr/vbit/aaddr/abit latched fault config; we/addr access;
//        old_word stored word, new_word write word, rd_word raw read word;
//        eff_addr address actually accessed, wr_word word to store,
//        vic_we/vic_inv victim bit update (invert or force 1),
//        rd_out corrected read word, hit fault changed behaviour this cycle.
module fault_mem_inject
  import fault_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic [2:0]                  ftype,
  input  logic [ADDR_WIDTH-1:0]       vaddr,
  input  logic [$clog2(DATA_WIDTH)-1:0] vbit,
  input  logic [ADDR_WIDTH-1:0]       aaddr,
  input  logic [$clog2(DATA_WIDTH)-1:0] abit,
  input  logic                        we,
  input  logic [ADDR_WIDTH-1:0]       addr,
  input  logic [DATA_WIDTH-1:0]       old_word,
  input  logic [DATA_WIDTH-1:0]       new_word,
  input  logic [DATA_WIDTH-1:0]       rd_word,
  output logic [ADDR_WIDTH-1:0]       eff_addr,
  output logic [DATA_WIDTH-1:0]       wr_word,
  output logic                        vic_we,
  output logic                        vic_inv,
  output logic [DATA_WIDTH-1:0]       rd_out,
  output logic                        hit
);

  logic [DATA_WIDTH-1:0] vmask;
  logic [DATA_WIDTH-1:0] amask;
  logic is_v, old_v, new_v, rd_v, old_a, new_a;

  assign vmask = DATA_WIDTH'(bit_mask(32'(vbit)));
  assign amask = DATA_WIDTH'(bit_mask(32'(abit)));
  assign is_v  = (addr == vaddr);
  assign old_v = |(old_word & vmask);
  assign new_v = |(new_word & vmask);
  assign rd_v  = |(rd_word & vmask);
  assign old_a = |(old_word & amask);
  assign new_a = |(new_word & amask);

  // Stuck-at faults keep the ideal value in the array and force the victim
  // bit on the read path, so both the write and the read of a differing
  // value are visible as hits.
  always_comb begin
    eff_addr = addr;
    wr_word  = new_word;
    vic_we   = 1'b0;
    vic_inv  = 1'b0;
    rd_out   = rd_word;
    hit      = 1'b0;
    case (ftype)
      FT_SAF0: if (is_v) begin
        if (we) hit = new_v;
        else begin
          rd_out = rd_word & ~vmask;
          hit    = rd_v;
        end
      end
      FT_SAF1: if (is_v) begin
        if (we) hit = !new_v;
        else begin
          rd_out = rd_word | vmask;
          hit    = !rd_v;
        end
      end
      FT_TFUP: if (is_v && we && !old_v && new_v) begin
        wr_word = new_word & ~vmask;
        hit     = 1'b1;
      end
      FT_TFDN: if (is_v && we && old_v && !new_v) begin
        wr_word = new_word | vmask;
        hit     = 1'b1;
      end
      FT_CFIN, FT_CFID: if (we && (addr == aaddr) && !old_a && new_a) begin
        vic_we  = 1'b1;
        vic_inv = (ftype == FT_CFIN);
        hit     = 1'b1;
      end
      FT_ADF: if (is_v) begin
        eff_addr = aaddr;
        hit      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fault_mem_multi.sv
// rtl/fault_mem_multi.sv - single-port memory model with one runtime-selectable fault
// Purpose: behavioural MBIST target memory with a configurable fault and hit counter.
// Ports: clk, rst (sync, active high); write_read (1 write / 0 read), address,
//        wdata, rdata (2-cycle read latency); cfg_load with cfg_type/cfg_vaddr/
//        cfg_vbit/cfg_aaddr/cfg_abit fault config; fault_active, fault_hits.
module fault_mem_multi
  import fault_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int WDATA_LAG  = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          write_read,
  input  logic [ADDR_WIDTH-1:0]         address,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH-1:0]         rdata,
  input  logic                          cfg_load,
  input  logic [2:0]                    cfg_type,
  input  logic [ADDR_WIDTH-1:0]         cfg_vaddr,
  input  logic [$clog2(DATA_WIDTH)-1:0] cfg_vbit,
  input  logic [ADDR_WIDTH-1:0]         cfg_aaddr,
  input  logic [$clog2(DATA_WIDTH)-1:0] cfg_abit,
  output logic                          fault_active,
  output logic [CNT_WIDTH-1:0]          fault_hits
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [2:0]                    c_type;
  logic [ADDR_WIDTH-1:0]         c_vaddr, c_aaddr;
  logic [$clog2(DATA_WIDTH)-1:0] c_vbit, c_abit;
  logic [DATA_WIDTH-1:0]         wdata_q, rd_q;
  logic [2:0]                    load_type;

  logic [ADDR_WIDTH-1:0] eff_addr;
  logic [DATA_WIDTH-1:0] wd, old_word, wr_word, rd_out, vmask;
  logic in_range, v_in_range, vic_we, vic_inv, hit;

  assign wd         = (WDATA_LAG != 0) ? wdata_q : wdata;
  assign in_range   = ({1'b0, eff_addr} < DEPTH_L);
  assign v_in_range = ({1'b0, c_vaddr} < DEPTH_L);
  assign old_word   = in_range ? mem[eff_addr] : '0;
  assign vmask      = DATA_WIDTH'(bit_mask(32'(c_vbit)));

  // A coupling fault whose aggressor is its own victim is meaningless.
  always_comb begin
    load_type = cfg_type;
    if ((cfg_type == FT_CFIN || cfg_type == FT_CFID) && cfg_aaddr == cfg_vaddr)
      load_type = FT_NONE;
  end

  fault_mem_inject #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_inject (
    .ftype    (c_type),
    .vaddr    (c_vaddr),
    .vbit     (c_vbit),
    .aaddr    (c_aaddr),
    .abit     (c_abit),
    .we       (write_read),
    .addr     (address),
    .old_word (old_word),
    .new_word (wd),
    .rd_word  (old_word),
    .eff_addr (eff_addr),
    .wr_word  (wr_word),
    .vic_we   (vic_we),
    .vic_inv  (vic_inv),
    .rd_out   (rd_out),
    .hit      (hit)
  );

  // Array is never reset; a write in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!rst && write_read && in_range) begin
      mem[eff_addr] <= wr_word;
      if (vic_we && v_in_range)
        mem[c_vaddr] <= vic_inv ? (mem[c_vaddr] ^ vmask) : (mem[c_vaddr] | vmask);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdata_q      <= '0;
      rd_q         <= '0;
      rdata        <= '0;
      c_type       <= FT_NONE;
      c_vaddr      <= '0;
      c_vbit       <= '0;
      c_aaddr      <= '0;
      c_abit       <= '0;
      fault_active <= 1'b0;
      fault_hits   <= '0;
    end else begin
      wdata_q <= wdata;
      // rd_q only moves on reads, so rdata holds across write cycles.
      if (!write_read) rd_q <= in_range ? rd_out : '0;
      rdata <= rd_q;
      if (cfg_load) begin
        c_type       <= load_type;
        c_vaddr      <= cfg_vaddr;
        c_vbit       <= cfg_vbit;
        c_aaddr      <= cfg_aaddr;
        c_abit       <= cfg_abit;
        fault_active <= (load_type != FT_NONE);
      end
      if (hit && in_range && fault_hits != '1)
        fault_hits <= fault_hits + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fault_mem_multi.sv
// tb/tb_fault_mem_multi.sv - directed table-driven bench for fault_mem_multi
module tb_fault_mem_multi;
  import fault_mem_pkg::*;

  localparam int CW = 4;
  localparam logic [3:0] PARK = 4'd15;

  logic       clk = 1'b0;
  logic       rst;
  logic       write_read;
  logic [3:0] address;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       cfg_load;
  logic [2:0] cfg_type;
  logic [3:0] cfg_vaddr, cfg_aaddr;
  logic [2:0] cfg_vbit, cfg_abit;
  logic       fault_active;
  logic [CW-1:0] fault_hits;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fault_mem_multi #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .WDATA_LAG(1), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .write_read(write_read), .address(address),
    .wdata(wdata), .rdata(rdata), .cfg_load(cfg_load), .cfg_type(cfg_type),
    .cfg_vaddr(cfg_vaddr), .cfg_vbit(cfg_vbit), .cfg_aaddr(cfg_aaddr),
    .cfg_abit(cfg_abit), .fault_active(fault_active), .fault_hits(fault_hits)
  );

  localparam int K_CFG = 0, K_WR = 1, K_RD = 2;

  typedef struct {
    int         kind;
    logic [2:0] t;
    logic [3:0] va;
    logic [2:0] vb;
    logic [3:0] aa;
    logic [2:0] ab;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] exp_d;   // rdata for reads, fault_active for config
    int         exp_h;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_read = 1'b0;
    address    = PARK;
    cfg_load   = 1'b0;
  endtask

  task automatic do_cfg(input logic [2:0] t, input logic [3:0] va, input logic [2:0] vb,
                        input logic [3:0] aa, input logic [2:0] ab);
    cfg_type = t; cfg_vaddr = va; cfg_vbit = vb; cfg_aaddr = aa; cfg_abit = ab;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  // Write data is presented one cycle ahead of the write itself.
  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    wdata = d;
    idle();
    tick();
    write_read = 1'b1;
    address    = a;
    tick();
    idle();
  endtask

  task automatic do_read(input logic [3:0] a);
    write_read = 1'b0;
    address    = a;
    tick();
    address = PARK;
    tick();
  endtask

  function automatic vec_t mk(input int k, input logic [2:0] t, input logic [3:0] va,
                              input logic [2:0] vb, input logic [3:0] aa, input logic [2:0] ab,
                              input logic [3:0] addr, input logic [7:0] data,
                              input logic [7:0] exp_d, input int exp_h);
    vec_t v;
    v.kind = k; v.t = t; v.va = va; v.vb = vb; v.aa = aa; v.ab = ab;
    v.addr = addr; v.data = data; v.exp_d = exp_d; v.exp_h = exp_h;
    return v;
  endfunction

  initial begin
    // Hit counts below are cumulative across the whole table.
    vq.push_back(mk(K_CFG, FT_NONE, 0, 0, 0, 0, 0, 0, 8'd0, 0));
    vq.push_back(mk(K_WR,  0, 0, 0, 0, 0, 4'd3, 8'hA5, 0, 0));
    vq.push_back(mk(K_RD,  0, 0, 0, 0, 0, 4'd3, 0, 8'hA5, 0));
    // SAF1 v5 b2
    vq.push_back(mk(K_CFG, FT_SAF1, 4'd5, 3'd2, 0, 0, 0, 0, 8'd1, 0));
    vq.push_back(mk(K_WR,  0, 0, 0, 0, 0, 4'd5, 8'h00, 0, 1));
    vq.push_back(mk(K_RD,  0, 0, 0, 0, 0, 4'd5, 0, 8'h04, 2));
    vq.push_back(mk(K_WR,  0, 0, 0, 0, 0, 4'd6, 8'h5A, 0, 2));
    vq.push_back(mk(K_RD,  0, 0, 0, 0, 0, 4'd6, 0, 8'h5A, 2));
    vq.push_back(mk(K_WR,  0, 0, 0, 0, 0, 4'd5, 8'h04, 0, 2));
    vq.push_back(mk(K_RD,  0, 0, 0, 0, 0, 4'd5, 0, 8'h04, 2));
    // TFUP v2 b1
    vq.push_back(mk(K_CFG, FT_TFUP, 4'd2, 3'd1, 0, 0, 0, 0, 8'd1, 2));
    vq.push_back(mk(K_WR,  0, 0, 0, 0, 0, 4'd2, 8'h00, 0, 2));
    vq.push_back(mk(K_WR,  0, 0, 0, 0, 0, 4'd2, 8'h02, 0, 3));
    vq.push_back(mk(K_RD,  0, 0, 0, 0, 0, 4'd2, 0, 8'h00, 3));
    vq.push_back(mk(K_WR,  0, 0, 0, 0, 0, 4'd2, 8'hFF, 0, 4));
    vq.push_back(mk(K_RD,  0, 0, 0, 0, 0, 4'd2, 0, 8'hFD, 4));
    // CFID a7 b1 -> v8 b3
    vq.push_back(mk(K_CFG, FT_CFID, 4'd8, 3'd3, 4'd7, 3'd1, 0, 0, 8'd1, 4));
    vq.push_back(mk(K_WR,  0, 0, 0, 0, 0, 4'd7, 8'h00, 0, 4));
    vq.push_back(mk(K_WR,  0, 0, 0, 0, 0, 4'd8, 8'h00, 0, 4));
    vq.push_back(mk(K_WR,  0, 0, 0, 0, 0, 4'd7, 8'h02, 0, 5));
    vq.push_back(mk(K_RD,  0, 0, 0, 0, 0, 4'd8, 0, 8'h08, 5));
    vq.push_back(mk(K_RD,  0, 0, 0, 0, 0, 4'd7, 0, 8'h02, 5));
    vq.push_back(mk(K_WR,  0, 0, 0, 0, 0, 4'd7, 8'h02, 0, 5));
    vq.push_back(mk(K_RD,  0, 0, 0, 0, 0, 4'd8, 0, 8'h08, 5));
    // CFIN a7 b1 -> v8 b3: inverts the 1 left by CFID
    vq.push_back(mk(K_CFG, FT_CFIN, 4'd8, 3'd3, 4'd7, 3'd1, 0, 0, 8'd1, 5));
    vq.push_back(mk(K_WR,  0, 0, 0, 0, 0, 4'd7, 8'h00, 0, 5));
    vq.push_back(mk(K_WR,  0, 0, 0, 0, 0, 4'd7, 8'h02, 0, 6));
    vq.push_back(mk(K_RD,  0, 0, 0, 0, 0, 4'd8, 0, 8'h00, 6));
    // CFIN with aggressor == victim behaves as no fault
    vq.push_back(mk(K_CFG, FT_CFIN, 4'd7, 3'd3, 4'd7, 3'd1, 0, 0, 8'd0, 6));
    vq.push_back(mk(K_WR,  0, 0, 0, 0, 0, 4'd7, 8'h00, 0, 6));
    vq.push_back(mk(K_WR,  0, 0, 0, 0, 0, 4'd7, 8'h02, 0, 6));
    vq.push_back(mk(K_RD,  0, 0, 0, 0, 0, 4'd7, 0, 8'h02, 6));
    // ADF v4 -> alias 9
    vq.push_back(mk(K_CFG, FT_ADF, 4'd4, 3'd0, 4'd9, 3'd0, 0, 0, 8'd1, 6));
    vq.push_back(mk(K_WR,  0, 0, 0, 0, 0, 4'd4, 8'h11, 0, 7));
    vq.push_back(mk(K_RD,  0, 0, 0, 0, 0, 4'd9, 0, 8'h11, 7));
    vq.push_back(mk(K_RD,  0, 0, 0, 0, 0, 4'd4, 0, 8'h11, 8));
    // SAF0 v10 b7
    vq.push_back(mk(K_CFG, FT_SAF0, 4'd10, 3'd7, 0, 0, 0, 0, 8'd1, 8));
    vq.push_back(mk(K_WR,  0, 0, 0, 0, 0, 4'd10, 8'hFF, 0, 9));
    vq.push_back(mk(K_RD,  0, 0, 0, 0, 0, 4'd10, 0, 8'h7F, 10));

    rst = 1'b1; wdata = 8'h00;
    cfg_type = FT_NONE; cfg_vaddr = 0; cfg_vbit = 0; cfg_aaddr = 0; cfg_abit = 0;
    idle();
    tick(); tick();
    check("reset rdata", 32'(rdata), 32'h0);
    check("reset fault_hits", 32'(fault_hits), 32'h0);
    check("reset fault_active", 32'(fault_active), 32'h0);
    rst = 1'b0;
    tick();

    foreach (vq[i]) begin
      case (vq[i].kind)
        K_CFG: begin
          do_cfg(vq[i].t, vq[i].va, vq[i].vb, vq[i].aa, vq[i].ab);
          check($sformatf("vec%0d fault_active", i), 32'(fault_active), 32'(vq[i].exp_d[0]));
        end
        K_WR: do_write(vq[i].addr, vq[i].data);
        default: begin
          do_read(vq[i].addr);
          check($sformatf("vec%0d rdata", i), 32'(rdata), 32'(vq[i].exp_d));
        end
      endcase
      check($sformatf("vec%0d fault_hits", i), 32'(fault_hits), 32'(vq[i].exp_h));
    end

    // Saturation: ADF counts every access to the victim address.
    do_cfg(FT_ADF, 4'd4, 3'd0, 4'd9, 3'd0);
    write_read = 1'b0;
    address    = 4'd4;
    for (int k = 0; k < 5; k++) tick();
    check("sat reach", 32'(fault_hits), 32'd15);
    tick();
    check("sat hold", 32'(fault_hits), 32'd15);
    idle();

    // Reset two cycles after a read issue, with a competing cfg_load.
    write_read = 1'b0;
    address    = 4'd3;
    tick();
    address = PARK;
    tick();
    check("pre-reset rdata", 32'(rdata), 32'hA5);
    rst = 1'b1;
    cfg_type = FT_SAF1; cfg_vaddr = 4'd3; cfg_vbit = 3'd0; cfg_load = 1'b1;
    tick();
    check("mid-reset rdata", 32'(rdata), 32'h0);
    check("mid-reset fault_hits", 32'(fault_hits), 32'h0);
    check("mid-reset fault_active", 32'(fault_active), 32'h0);
    rst = 1'b0;
    idle();
    tick();
    check("post-reset fault_active", 32'(fault_active), 32'h0);
    do_read(4'd3);
    check("post-reset rd3", 32'(rdata), 32'hA5);
    do_read(4'd9);
    check("post-reset rd9", 32'(rdata), 32'h11);
    do_read(4'd2);
    check("post-reset rd2", 32'(rdata), 32'hFD);
    check("post-reset hits", 32'(fault_hits), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
